// File: rtl/ripple_count_monitor.sv
// Samples an asynchronous 4-bit ripple-counter output, filters ripple glitches,
// extends the count with a wrap counter and offers it over a valid/ready port.
module ripple_count_monitor #(
  parameter int unsigned WRAP_W    = 4,
  parameter int unsigned MATCH_VAL = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          cnt_in,
  input  logic                out_ready,
  input  logic                clr_ovr,
  output logic                out_valid,
  output logic [WRAP_W+3:0]   out_data,
  output logic                match,
  output logic                overrun
);

  localparam int unsigned EXT_W  = WRAP_W + 4;
  localparam int unsigned INIT_W = 2;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [3:0]          s1;
  logic [3:0]          s2;
  logic [3:0]          s3;
  logic [3:0]          acc;
  logic [3:0]          acc_nxt;
  logic [WRAP_W-1:0]   wrap_cnt;
  logic [WRAP_W-1:0]   wrap_nxt;
  logic [INIT_W-1:0]   init_cnt;
  logic [INIT_W-1:0]   init_nxt;
  logic [EXT_W-1:0]    data_nxt;
  logic                valid_nxt;
  logic                match_nxt;
  logic                ovr_nxt;

  logic                stable_c;
  logic                update_c;
  logic [WRAP_W-1:0]   wrap_inc_c;
  logic [EXT_W-1:0]    ext_c;

  // Three-stage synchronizer; the last two stages double as the glitch filter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 4'd0;
      s2 <= 4'd0;
      s3 <= 4'd0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Accept a value only once it has been seen on two consecutive samples.
  always_comb begin
    stable_c   = (s2 == s3);
    update_c   = (state != INIT) && stable_c && (s3 != acc);
    wrap_inc_c = (s3 < acc) ? wrap_cnt + WRAP_W'(1) : wrap_cnt;
    ext_c      = {wrap_inc_c, s3};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_nxt = state;
    init_nxt  = init_cnt;
    acc_nxt   = acc;
    wrap_nxt  = wrap_cnt;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    match_nxt = 1'b0;
    ovr_nxt   = overrun;

    // Clear first so that a same-cycle overrun set below takes precedence.
    if (clr_ovr) begin
      ovr_nxt = 1'b0;
    end

    unique case (state)
      INIT: begin
        init_nxt = init_cnt + INIT_W'(1);
        if (init_cnt == INIT_W'(3)) begin
          acc_nxt   = s3;
          wrap_nxt  = '0;
          init_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (update_c) begin
          acc_nxt   = s3;
          wrap_nxt  = wrap_inc_c;
          data_nxt  = ext_c;
          valid_nxt = 1'b1;
          match_nxt = (ext_c == EXT_W'(MATCH_VAL));
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (update_c) begin
          acc_nxt   = s3;
          wrap_nxt  = wrap_inc_c;
          data_nxt  = ext_c;
          valid_nxt = 1'b1;
          match_nxt = (ext_c == EXT_W'(MATCH_VAL));
          // Replacing unconsumed data is an overrun; a same-edge handshake is not.
          if (!out_ready) begin
            ovr_nxt = 1'b1;
          end
        end else if (out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      init_cnt  <= '0;
      acc       <= 4'd0;
      wrap_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      match     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      init_cnt  <= init_nxt;
      acc       <= acc_nxt;
      wrap_cnt  <= wrap_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      match     <= match_nxt;
      overrun   <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor with a queue-based output scoreboard.
module tb_ripple_count_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] cnt_in;
  logic       out_ready;
  logic       clr_ovr;
  logic       out_valid;
  logic [7:0] out_data;
  logic       match;
  logic       overrun;

  typedef struct {
    logic [7:0] data;
    logic       m;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fails;
  logic       prev_valid;
  logic [7:0] prev_data;

  ripple_count_monitor #(.WRAP_W(4), .MATCH_VAL(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .match     (match),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic m);
    exp_t e;
    e.data = d;
    e.m    = m;
    exp_q.push_back(e);
  endtask

  // Monitor: every newly presented out_data is popped against the scoreboard.
  initial begin
    prev_valid = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (out_valid && (!prev_valid || out_data != prev_data)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_output: got %h expected none at %0t", out_data, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_data", 32'(out_data), 32'(e.data));
          chk("sb_match", 32'(match), 32'(e.m));
        end
      end else begin
        chk("stray_match", 32'(match), 32'(0));
      end
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b0;
    cnt_in    = 4'h3;
    out_ready = 1'b1;
    clr_ovr   = 1'b0;

    // Reset state
    tick(3);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_match", 32'(match), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));

    // Release with a constant input: no output at all
    reset = 1'b1;
    tick(10);
    chk("hold_no_valid", 32'(out_valid), 32'(0));

    // Latency: increment to 4 shows after the fourth edge
    cnt_in = 4'h4;
    push(8'h04, 1'b0);
    tick(3);
    chk("lat_k2_valid", 32'(out_valid), 32'(0));
    tick(1);
    chk("lat_k3_valid", 32'(out_valid), 32'(1));
    chk("lat_k3_data", 32'(out_data), 32'(8'h04));
    tick(2);
    chk("lat_consumed", 32'(out_valid), 32'(0));

    // Overrun: two updates without consumption
    out_ready = 1'b0;
    cnt_in = 4'h5;
    push(8'h05, 1'b0);
    tick(6);
    chk("ovr_first_data", 32'(out_data), 32'(8'h05));
    chk("ovr_first_flag", 32'(overrun), 32'(0));
    cnt_in = 4'h6;
    push(8'h06, 1'b0);
    tick(6);
    chk("ovr_second_data", 32'(out_data), 32'(8'h06));
    chk("ovr_second_valid", 32'(out_valid), 32'(1));
    chk("ovr_set", 32'(overrun), 32'(1));
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'(0));
    chk("ovr_data_held", 32'(out_data), 32'(8'h06));

    // Clear and set in the same cycle: set wins
    cnt_in  = 4'h7;
    clr_ovr = 1'b1;
    push(8'h07, 1'b0);
    tick(4);
    chk("ovr_set_wins", 32'(overrun), 32'(1));
    tick(1);
    chk("ovr_clear_after", 32'(overrun), 32'(0));
    clr_ovr   = 1'b0;
    out_ready = 1'b1;
    tick(1);
    chk("ovr_drained", 32'(out_valid), 32'(0));

    // Wrap: F then 0 extends into wrap count 1
    cnt_in = 4'hF;
    push(8'h0F, 1'b0);
    tick(6);
    cnt_in = 4'h0;
    push(8'h10, 1'b0);
    tick(6);

    // Single-sample glitch 7 -> 6 -> 7 is ignored
    cnt_in = 4'h7;
    push(8'h17, 1'b0);
    tick(6);
    cnt_in = 4'h6;
    tick(1);
    cnt_in = 4'h7;
    tick(6);
    chk("glitch_no_valid", 32'(out_valid), 32'(0));
    cnt_in = 4'h8;
    push(8'h18, 1'b0);
    tick(6);

    // Update and handshake on the same edge
    out_ready = 1'b0;
    cnt_in = 4'h9;
    push(8'h19, 1'b0);
    tick(6);
    cnt_in = 4'hA;
    push(8'h1A, 1'b0);
    tick(3);
    out_ready = 1'b1;
    tick(1);
    chk("xfer_upd_valid", 32'(out_valid), 32'(1));
    chk("xfer_upd_data", 32'(out_data), 32'(8'h1A));
    chk("xfer_upd_ovr", 32'(overrun), 32'(0));
    tick(1);
    chk("xfer_upd_drain", 32'(out_valid), 32'(0));

    // Wrap up to wrap count 6, then 4 gives 0x64 and match
    for (int w = 2; w <= 6; w++) begin
      cnt_in = 4'hF;
      push(8'((w - 1) * 16 + 15), 1'b0);
      tick(6);
      cnt_in = 4'h0;
      push(8'(w * 16), 1'b0);
      tick(6);
    end
    cnt_in = 4'h4;
    push(8'h64, 1'b1);
    tick(4);
    chk("match_pulse", 32'(match), 32'(1));
    chk("match_data", 32'(out_data), 32'(8'h64));
    tick(1);
    chk("match_single", 32'(match), 32'(0));
    tick(4);

    // Reset while pending with overrun set
    out_ready = 1'b0;
    cnt_in = 4'h5;
    push(8'h65, 1'b0);
    tick(6);
    cnt_in = 4'h6;
    push(8'h66, 1'b0);
    tick(6);
    chk("pend_overrun", 32'(overrun), 32'(1));
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("pend_rst_valid", 32'(out_valid), 32'(0));
    chk("pend_rst_ovr", 32'(overrun), 32'(0));
    chk("pend_rst_data", 32'(out_data), 32'(0));
    tick(12);
    chk("post_rst_quiet", 32'(out_valid), 32'(0));
    out_ready = 1'b1;
    cnt_in = 4'h2;
    push(8'h12, 1'b0);
    tick(8);

    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ripple_count_monitor.md
RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 Parameter: WRAP_W, 4, width of wrap-extension counter; extended count width EXT_W = WRAP_W+4.
REQ-002 Parameter: MATCH_VAL, 8'd100, extended-count value that raises match.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; sampled low at a rising edge of clk resets the block.
REQ-005 cnt_in  input  4  q output of the upstream 4-bit ripple counter; asynchronous to clk, may glitch while rippling.
REQ-006 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-007 clr_ovr  input  1  clears overrun sticky flag.
REQ-008 out_valid  output  EXT_W-bit-qualified  1  out_data holds an unconsumed extended count.
REQ-009 out_data  output  EXT_W  {wrap_cnt, accepted count}.
REQ-010 match  output  1  one-cycle pulse when a newly accepted extended count equals MATCH_VAL.
REQ-011 overrun  output  1  sticky: a pending out_data was replaced before consumption.

Function
REQ-012 Sync/filter: s1<=cnt_in, s2<=s1, s3<=s2 every edge; stable = (s2==s3).
REQ-013 State machine states INIT, IDLE, PEND; reset enters INIT.
REQ-014 INIT: hold 3 clocks after reset release; on 4th edge load acc<=s3, wrap_cnt<=0, no output, go IDLE.
REQ-015 Update event (IDLE/PEND): stable && s3 != acc; on that edge acc<=s3.
REQ-016 Wrap: on update event, if s3 < acc (unsigned), wrap_cnt increments modulo 2^WRAP_W; otherwise unchanged.
REQ-017 On update event out_data<={new wrap_cnt, s3}, out_valid<=1, state->PEND.
REQ-018 Latency: new cnt_in value first sampled at edge k and held stable -> out_valid high after edge k+3.
REQ-019 Values changing on consecutive samples (stable=0) are never accepted; no output, no wrap.
REQ-020 PEND: out_valid && out_ready at an edge with no update event -> out_valid<=0, state->IDLE.
REQ-021 PEND with update event and out_ready=0: out_data overwritten, out_valid stays 1, overrun<=1.
REQ-022 PEND with update event and out_ready=1: transfer completes on old data, new data loaded, out_valid stays 1, overrun unchanged.
REQ-023 out_data stable while out_valid=1 and no update event.
REQ-024 match<=1 for exactly the edge following an update event whose new extended count == MATCH_VAL; else 0.
REQ-025 clr_ovr=1 clears overrun; simultaneous set condition wins (overrun stays 1).
REQ-026 wrap_cnt wrap from all-ones to 0 is silent; no flag.

Reset
REQ-027 While reset low at edge: s1..s3=0, acc=0, wrap_cnt=0, out_valid=0, out_data=0, match=0, overrun=0, state=INIT.
REQ-028 Reset asserted in PEND discards pending data; no transfer reported.
REQ-029 Reset has priority over all other inputs including out_ready and clr_ovr.

Verification
REQ-030 Reset release with cnt_in=4'h3 held -> no out_valid ever; after increment to 4'h4 held, out_valid=1, out_data=8'h04 after edge k+3.
REQ-031 cnt_in steps 4'hF then 4'h0, out_ready=1 -> outputs 8'h0F then 8'h10 (wrap_cnt=1).
REQ-032 cnt_in glitches 4'h7->4'h6 for one sample, returns to 4'h7 -> no output, acc unchanged.
REQ-033 out_ready=0, two accepted updates 8'h05, 8'h06 -> out_data=8'h06, overrun=1; clr_ovr pulse -> overrun=0.
REQ-034 Drive counter through 6 wraps then to 4'h4 (ext 8'h64=100) -> match single-cycle pulse one edge after acceptance.
REQ-035 Reset low for one edge while PEND -> out_valid=0, overrun=0, state INIT, next output only after new stable change.
